// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode encoding and helpers shared by the universal shift register and its users
package usr_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_SHL   = 3'b001;
  localparam mode_t MODE_SHR   = 3'b010;
  localparam mode_t MODE_LOAD  = 3'b011;
  localparam mode_t MODE_ROL   = 3'b100;
  localparam mode_t MODE_ROR   = 3'b101;
  localparam mode_t MODE_CLEAR = 3'b110;
  localparam mode_t MODE_RSVD  = 3'b111;

  // Shifts and rotates in either direction all advance the word counter.
  function automatic logic is_shift_op(input mode_t mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

  // Load and clear both start a fresh word.
  function automatic logic is_restart_op(input mode_t mode);
    return (mode == MODE_LOAD) || (mode == MODE_CLEAR);
  endfunction

endpackage

// File: rtl/shift_word_counter.sv
// rtl/shift_word_counter.sv - counts shift/rotate operations and pulses word_done at each full word
module shift_word_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next count: restart wins over step so a load/clear on the last edge suppresses the pulse.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (step) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and pulse registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt       = cnt_q;
  assign word_done = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - parametrised shift/rotate/load register with word-complete counter
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("universal_shift_register: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             cnt_step;
  logic             cnt_clr;

  // Data path: select the next register value from the operation mode.
  always_comb begin
    out_d = out_q;
    if (en) begin
      case (mode)
        MODE_SHL:   out_d = {out_q[WIDTH-2:0], sin_r};
        MODE_SHR:   out_d = {sin_l, out_q[WIDTH-1:1]};
        MODE_LOAD:  out_d = pin;
        MODE_ROL:   out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        MODE_ROR:   out_d = {out_q[0], out_q[WIDTH-1:1]};
        MODE_CLEAR: out_d = '0;
        default:    out_d = out_q;
      endcase
    end
  end

  // Counter controls: only enabled edges can step or restart the word.
  always_comb begin
    cnt_step = en && is_shift_op(mode);
    cnt_clr  = en && is_restart_op(mode);
  end

  // Data register; clear goes to zero, only reset restores RESET_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= RESET_VAL;
    end else begin
      out_q <= out_d;
    end
  end

  shift_word_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .step      (cnt_step),
    .clr       (cnt_clr),
    .cnt       (shift_cnt),
    .word_done (word_done)
  );

  assign out      = out_q;
  assign sout_msb = out_q[WIDTH-1];
  assign sout_lsb = out_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - self-checking bench for universal_shift_register
module tb_universal_shift_register;
  import usr_pkg::*;

  typedef struct {
    logic       en;
    mode_t      mode;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] pin;
    logic [3:0] exp_out;
    logic [2:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  logic       clk = 1'b0;
  int         total = 0;
  int         bad = 0;

  // 4-bit instance with non-zero reset value
  logic       a_rst = 1'b1, a_en = 1'b0, a_sin_r = 1'b0, a_sin_l = 1'b0;
  mode_t      a_mode = MODE_HOLD;
  logic [3:0] a_pin = '0;
  logic [3:0] a_out;
  logic       a_msb, a_lsb, a_done;
  logic [2:0] a_cnt;

  // 8-bit instance for the long-word boundary cases
  logic       b_rst = 1'b0, b_en = 1'b0, b_sin_r = 1'b0, b_sin_l = 1'b0;
  mode_t      b_mode = MODE_HOLD;
  logic [7:0] b_pin = '0;
  logic [7:0] b_out;
  logic       b_msb, b_lsb, b_done;
  logic [3:0] b_cnt;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(4), .RESET_VAL(4'b1010)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .sin_r(a_sin_r), .sin_l(a_sin_l),
    .pin(a_pin), .out(a_out), .sout_msb(a_msb), .sout_lsb(a_lsb),
    .shift_cnt(a_cnt), .word_done(a_done)
  );

  universal_shift_register #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .sin_r(b_sin_r), .sin_l(b_sin_l),
    .pin(b_pin), .out(b_out), .sout_msb(b_msb), .sout_lsb(b_lsb),
    .shift_cnt(b_cnt), .word_done(b_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input mode_t mode, input logic sr, input logic sl,
                              input logic [3:0] pin, input logic [3:0] eo,
                              input logic [2:0] ec, input logic ed);
    vec_t v;
    v.en = en; v.mode = mode; v.sin_r = sr; v.sin_l = sl; v.pin = pin;
    v.exp_out = eo; v.exp_cnt = ec; v.exp_done = ed;
    return v;
  endfunction

  task automatic check_a(input string tag, input logic [3:0] eo, input logic [2:0] ec,
                         input logic ed);
    chk({tag, "_out"}, 32'(a_out), 32'(eo));
    chk({tag, "_cnt"}, 32'(a_cnt), 32'(ec));
    chk({tag, "_done"}, 32'(a_done), 32'(ed));
    chk({tag, "_msb"}, 32'(a_msb), 32'(eo[3]));
    chk({tag, "_lsb"}, 32'(a_lsb), 32'(eo[0]));
  endtask

  task automatic step_b(input mode_t mode, input logic sr);
    b_en = 1'b1; b_mode = mode; b_sin_r = sr;
    @(posedge clk); #1;
  endtask

  vec_t vq[$];
  int   pulses;
  int   first_pulse;
  int   second_pulse;

  initial begin
    // Reset asserted mid-cycle must act without any clock edge.
    #13 a_rst = 1'b0;
    #1 check_a("reset_async", 4'b1010, 3'd0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    a_rst = 1'b1;
    check_a("reset_hold", 4'b1010, 3'd0, 1'b0);

    // en mode sr sl pin exp_out cnt done
    vq.push_back(mk(1, MODE_CLEAR, 0, 0, 4'h0, 4'b0000, 3'd0, 0));
    vq.push_back(mk(1, MODE_SHL,   1, 0, 4'h0, 4'b0001, 3'd1, 0));
    vq.push_back(mk(1, MODE_SHL,   1, 0, 4'h0, 4'b0011, 3'd2, 0));
    vq.push_back(mk(1, MODE_SHL,   0, 0, 4'h0, 4'b0110, 3'd3, 0));
    vq.push_back(mk(1, MODE_SHL,   1, 0, 4'h0, 4'b1101, 3'd0, 1));
    vq.push_back(mk(1, MODE_HOLD,  0, 0, 4'h0, 4'b1101, 3'd0, 0));
    vq.push_back(mk(1, MODE_LOAD,  0, 0, 4'h3, 4'b0011, 3'd0, 0));
    vq.push_back(mk(1, MODE_SHR,   0, 1, 4'h0, 4'b1001, 3'd1, 0));
    vq.push_back(mk(1, MODE_LOAD,  0, 0, 4'h6, 4'b0110, 3'd0, 0));
    vq.push_back(mk(1, MODE_LOAD,  0, 0, 4'h8, 4'b1000, 3'd0, 0));
    vq.push_back(mk(1, MODE_ROL,   0, 0, 4'h0, 4'b0001, 3'd1, 0));
    vq.push_back(mk(1, MODE_ROL,   0, 0, 4'h0, 4'b0010, 3'd2, 0));
    vq.push_back(mk(1, MODE_ROL,   0, 0, 4'h0, 4'b0100, 3'd3, 0));
    vq.push_back(mk(1, MODE_ROL,   0, 0, 4'h0, 4'b1000, 3'd0, 1));
    vq.push_back(mk(1, MODE_ROR,   0, 0, 4'h0, 4'b0100, 3'd1, 0));
    vq.push_back(mk(1, MODE_ROR,   0, 0, 4'h0, 4'b0010, 3'd2, 0));
    vq.push_back(mk(0, MODE_SHL,   1, 1, 4'hF, 4'b0010, 3'd2, 0));
    vq.push_back(mk(0, MODE_LOAD,  1, 1, 4'hF, 4'b0010, 3'd2, 0));
    vq.push_back(mk(0, MODE_CLEAR, 1, 1, 4'hF, 4'b0010, 3'd2, 0));
    vq.push_back(mk(1, MODE_RSVD,  1, 1, 4'hF, 4'b0010, 3'd2, 0));
    vq.push_back(mk(1, MODE_RSVD,  1, 1, 4'hF, 4'b0010, 3'd2, 0));
    vq.push_back(mk(1, MODE_SHR,   0, 0, 4'h0, 4'b0001, 3'd3, 0));
    vq.push_back(mk(1, MODE_SHL,   1, 0, 4'h0, 4'b0011, 3'd0, 1));
    vq.push_back(mk(0, MODE_SHL,   1, 0, 4'h0, 4'b0011, 3'd0, 0));
    vq.push_back(mk(1, MODE_SHL,   0, 0, 4'h0, 4'b0110, 3'd1, 0));
    vq.push_back(mk(1, MODE_SHL,   0, 0, 4'h0, 4'b1100, 3'd2, 0));
    vq.push_back(mk(1, MODE_SHL,   1, 0, 4'h0, 4'b1001, 3'd3, 0));
    vq.push_back(mk(1, MODE_LOAD,  0, 0, 4'h5, 4'b0101, 3'd0, 0));
    vq.push_back(mk(1, MODE_HOLD,  0, 0, 4'h0, 4'b0101, 3'd0, 0));

    foreach (vq[i]) begin
      a_en = vq[i].en; a_mode = vq[i].mode; a_sin_r = vq[i].sin_r;
      a_sin_l = vq[i].sin_l; a_pin = vq[i].pin;
      @(posedge clk); #1;
      check_a($sformatf("v%0d", i), vq[i].exp_out, vq[i].exp_cnt, vq[i].exp_done);
    end

    // Partial word interrupted by reset: state returns to reset value, count restarts.
    a_en = 1'b1; a_mode = MODE_SHL; a_sin_r = 1'b1;
    @(posedge clk); #1 check_a("pre_rst1", 4'b1011, 3'd1, 1'b0);
    @(posedge clk); #1 check_a("pre_rst2", 4'b0111, 3'd2, 1'b0);
    @(posedge clk); #1 check_a("pre_rst3", 4'b1111, 3'd3, 1'b0);
    #3 a_rst = 1'b0;
    #1 check_a("mid_rst", 4'b1010, 3'd0, 1'b0);
    @(posedge clk); #1;
    check_a("mid_rst_hold", 4'b1010, 3'd0, 1'b0);
    a_rst = 1'b1; a_sin_r = 1'b0;
    @(posedge clk); #1 check_a("post_rst", 4'b0100, 3'd1, 1'b0);
    a_en = 1'b0;

    // 8-bit: seven shifts then clear on the would-be eighth edge.
    b_rst = 1'b1;
    chk("b_reset_out", 32'(b_out), 32'h0);
    step_b(MODE_CLEAR, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step_b(MODE_SHL, 1'b1);
      chk($sformatf("b_shl%0d_out", k), 32'(b_out), 32'((1 << k) - 1));
      chk($sformatf("b_shl%0d_cnt", k), 32'(b_cnt), 32'(k));
      chk($sformatf("b_shl%0d_done", k), 32'(b_done), 32'h0);
    end
    step_b(MODE_CLEAR, 1'b0);
    chk("b_clr_out", 32'(b_out), 32'h0);
    chk("b_clr_cnt", 32'(b_cnt), 32'h0);
    chk("b_clr_done", 32'(b_done), 32'h0);

    // Sixteen continuous shifts: one pulse per eight, with no gap between words.
    pulses = 0; first_pulse = -1; second_pulse = -1;
    for (int i = 0; i < 16; i++) begin
      step_b(MODE_SHL, 1'(i & 1));
      chk($sformatf("b_run%0d_cnt", i), 32'(b_cnt), 32'((i + 1) % 8));
      if (b_done === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else second_pulse = i;
      end
    end
    chk("b_pulse_count", 32'(pulses), 32'd2);
    chk("b_first_pulse", 32'(first_pulse), 32'd7);
    chk("b_second_pulse", 32'(second_pulse), 32'd15);
    chk("b_run_out", 32'(b_out), 32'h55);
    chk("b_run_msb", 32'(b_msb), 32'h0);
    chk("b_run_lsb", 32'(b_lsb), 32'h1);
    step_b(MODE_HOLD, 1'b0);
    chk("b_after_done", 32'(b_done), 32'h0);
    chk("b_after_out", 32'(b_out), 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the team's fixed 4-bit serial-in shift register. Adds parallel load, bidirectional shift, rotate, synchronous clear and a word-complete counter. Used in the digital clock datapath for digit serialisation/deserialisation (display driver and time-set input) and for general bit-stream staging.

Parameters:
WIDTH, 4, register width in bits; legal range 2..32, elaboration error outside it.
RESET_VAL, 0, value loaded into out on reset (WIDTH bits).
CNT_W, $clog2(WIDTH+1), width of shift_cnt; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
en  input  1  clock enable; 0 = all state holds
mode  input  3  operation select (encoding below)
sin_r  input  1  serial input entering at bit 0 on shift-left
sin_l  input  1  serial input entering at bit WIDTH-1 on shift-right
pin  input  WIDTH  parallel load data
out  output  WIDTH  register contents
sout_msb  output  1  equals out[WIDTH-1]
sout_lsb  output  1  equals out[0]
shift_cnt  output  CNT_W  shift/rotate operations since last load/clear/reset/word end
word_done  output  1  one-cycle pulse after WIDTH-th shift/rotate

Behaviour:
- Reset (rst=0, async): out=RESET_VAL, shift_cnt=0, word_done=0. Reset mid-operation discards any partial word; no pulse issued.
- All non-reset updates on rising clk; all outputs registered except sout_msb/sout_lsb (wired from out).
- en=0: out and shift_cnt hold, word_done <= 0.
- en=1, mode encoding:
  - 000 HOLD: out holds; shift_cnt holds.
  - 001 SHL: out <= {out[WIDTH-2:0], sin_r}.
  - 010 SHR: out <= {sin_l, out[WIDTH-1:1]}.
  - 011 LOAD: out <= pin; shift_cnt <= 0.
  - 100 ROL: out <= {out[WIDTH-2:0], out[WIDTH-1]}.
  - 101 ROR: out <= {out[0], out[WIDTH-1:1]}.
  - 110 CLEAR: out <= 0 (not RESET_VAL); shift_cnt <= 0.
  - 111 reserved: behaves as HOLD.
- Counter: on each SHL/SHR/ROL/ROR edge, if shift_cnt==WIDTH-1 then shift_cnt <= 0 and word_done <= 1, else shift_cnt <= shift_cnt+1 and word_done <= 0. On every other edge word_done <= 0 (single-cycle pulse, never held).
- word_done high in the cycle after the WIDTH-th operation's edge; back-to-back words give a pulse every WIDTH cycles without gaps.
- Mixing directions within a word is legal; every shift/rotate counts regardless of direction.
- LOAD/CLEAR on the same edge the count would reach WIDTH: load/clear wins, no pulse.
- Latency: 1 cycle from mode/en to out change; no combinational path from inputs to out.

Decomposition:
- Package usr_pkg: mode localparams (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROL, MODE_ROR, MODE_CLEAR) and the 3-bit mode typedef; shared with display driver and testbench.
- One sub-module is natural: shift_word_counter (CNT_W counter with wrap at WIDTH, clear, and word_done pulse). Data register stays in the top module.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'b1010, rst=0 mid-cycle -> out=1010, shift_cnt=0, word_done=0 immediately, without a clk edge.
- SHL serial-in: clear, then sin_r=1,1,0,1 on four SHL edges -> out=1101, shift_cnt 1,2,3,0, word_done=1 for exactly the cycle after the 4th edge.
- SHR + LOAD: load pin=0011, SHR with sin_l=1 -> out=1001, shift_cnt=1; LOAD pin=0110 -> out=0110, shift_cnt=0, no word_done.
- Rotate: load 1000, 4×ROL -> out sequence 0001,0010,0100,1000; word_done pulse; 2×ROR -> 0100 then 0010; sout_lsb/sout_msb track out[0]/out[3].
- Enable/hold/reserved: after 2 shifts, en=0 for 3 cycles then mode=111 for 2 cycles -> out and shift_cnt=2 unchanged, word_done stays 0.
- Boundary: WIDTH=8, 7 SHL then CLEAR on the 8th edge -> out=0, shift_cnt=0, no pulse; then 16 continuous SHL -> exactly two word_done pulses, 8 cycles apart.
